// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Pipeline <-> hazard-controller signal bundle.
//   Hazard inputs (pipeline -> controller):
//     rsD, rtD   Decode source registers
//     rtE        Execute load destination register
//     MtoRFSelE  Execute instruction is a load
//     BranchM    Memory-stage branch
//     ZeroM      Memory-stage zero flag
//     DMReqM     Memory-stage data-memory access active
//     DMRdyM     data memory completes access this cycle
//   Control outputs (controller -> pipeline):
//     StallF/D/E/M, FlushD/E/W, PCSrcM, Halted, StallCnt, FlushCnt
//   Modports: master = pipeline side, slave = controller side.
interface pipe_hazard_ctrl_if #(
    parameter int CW = 16
);
    logic [4:0]    rsD;
    logic [4:0]    rtD;
    logic [4:0]    rtE;
    logic          MtoRFSelE;
    logic          BranchM;
    logic          ZeroM;
    logic          DMReqM;
    logic          DMRdyM;

    logic          StallF;
    logic          StallD;
    logic          StallE;
    logic          StallM;
    logic          FlushD;
    logic          FlushE;
    logic          FlushW;
    logic          PCSrcM;
    logic          Halted;
    logic [CW-1:0] StallCnt;
    logic [CW-1:0] FlushCnt;

    modport master (
        output rsD, rtD, rtE, MtoRFSelE, BranchM, ZeroM, DMReqM, DMRdyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               PCSrcM, Halted, StallCnt, FlushCnt
    );

    modport slave (
        input  rsD, rtD, rtE, MtoRFSelE, BranchM, ZeroM, DMReqM, DMRdyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               PCSrcM, Halted, StallCnt, FlushCnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage pipeline. Resolves
//   load-use hazards, taken branches resolved in Memory, and multi-cycle
//   data-memory waits with a timeout that halts the pipeline until reset.
//   Keeps saturating stall-cycle and branch-flush counters.
//   Ports:
//     CLK  clock, all state updates on rising edge
//     RST  synchronous active-high reset
//     bus  pipe_hazard_ctrl_if.slave (hazard inputs, stall/flush outputs,
//          Halted flag, StallCnt/FlushCnt performance counters)
//   Parameters:
//     TMO  max consecutive data-memory wait cycles before halt (>=2)
//     CW   performance counter width (must match the interface CW)
module pipe_hazard_ctrl #(
    parameter int TMO = 16,
    parameter int CW  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int WW = (TMO > 2) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic memwait, lduse, brtaken;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w, pcsrc;
    logic br_act;

    assign memwait = bus.DMReqM & ~bus.DMRdyM;
    assign lduse   = bus.MtoRFSelE & (bus.rtE != 5'd0) &
                     ((bus.rtE == bus.rsD) | (bus.rtE == bus.rtD));
    assign brtaken = bus.BranchM & bus.ZeroM;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            wcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (stall_f && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (br_act && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        pcsrc   = 1'b0;
        br_act  = 1'b0;

        if (RST) begin
            // Bubble every stage while in reset; no stalls.
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
            state_n = RUN;
            wcnt_n  = '0;
        end else begin
            case (state)
                HALT: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                end
                default: begin
                    // RUN and MWAIT share the same hazard resolution; MWAIT
                    // only differs in carrying a non-zero wait count.
                    if (memwait) begin
                        // Any pending branch is held in M until DMRdyM.
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        stall_m = 1'b1;
                        flush_w = 1'b1;
                        if (wcnt == WW'(TMO - 1)) begin
                            state_n = HALT;
                        end else begin
                            state_n = MWAIT;
                            wcnt_n  = wcnt + 1'b1;
                        end
                    end else begin
                        state_n = RUN;
                        wcnt_n  = '0;
                        if (brtaken) begin
                            // Decode instruction is squashed, so lduse is moot.
                            pcsrc   = 1'b1;
                            flush_d = 1'b1;
                            flush_e = 1'b1;
                            br_act  = 1'b1;
                        end else if (lduse) begin
                            stall_f = 1'b1;
                            stall_d = 1'b1;
                            flush_e = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.StallF   = stall_f;
    assign bus.StallD   = stall_d;
    assign bus.StallE   = stall_e;
    assign bus.StallM   = stall_m;
    assign bus.FlushD   = flush_d;
    assign bus.FlushE   = flush_e;
    assign bus.FlushW   = flush_w;
    assign bus.PCSrcM   = pcsrc;
    assign bus.Halted   = (state == HALT);
    assign bus.StallCnt = stall_cnt;
    assign bus.FlushCnt = flush_cnt;

endmodule
